// File: rtl/mul2x2_seq_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mulsched_pkg
// Shared definitions for the 2x2-core sequencing multiplier.
//   state_t : controller states (IDLE, RUN, DONE)
//   CORE_W  : digit width handled by the external core (2 bits)
//   digits  : number of CORE_W-bit digits in an operand of a given width
// ---------------------------------------------------------------------------
package mulsched_pkg;

   localparam int CORE_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int digits(input int width);
      return width / CORE_W;
   endfunction

endpackage

// File: rtl/mul2x2_seq_scheduler_if.sv
// ---------------------------------------------------------------------------
// mul2x2_seq_scheduler_if
// Operand/result handshake bundle of the sequencing multiplier.
//   in_valid/in_ready/a/b : operand pair from the source
//   out_valid/out_ready/p : completed product to the consumer
// Modports: master = operand source / result consumer, slave = scheduler.
// ---------------------------------------------------------------------------
interface mul2x2_seq_scheduler_if #(
   parameter int WIDTH = 8
);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p
   );

endinterface

// File: rtl/mul2x2_seq_scheduler_counter.sv
// ---------------------------------------------------------------------------
// mul_digit_counter
// Nested (i,j) digit-pair counter: j is the inner index, i the outer one.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return both indices to 0 (wins over enable)
//   enable     : advance to the next digit pair
//   i, j       : current digit indices
//   last       : current pair is (K-1, K-1)
// ---------------------------------------------------------------------------
module mul_digit_counter #(
   parameter int K     = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [IDX_W-1:0] i,
   output logic [IDX_W-1:0] j,
   output logic             last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

   // Walk j across a full row of b digits before moving i to the next
   // digit of a; both wrap after the final pair so the counter is left
   // in a clean state even if it is not cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i <= '0;
         j <= '0;
      end else if (clear) begin
         i <= '0;
         j <= '0;
      end else if (enable) begin
         if (j == LAST_IDX) begin
            j <= '0;
            if (i == LAST_IDX) begin
               i <= '0;
            end else begin
               i <= i + 1'b1;
            end
         end else begin
            j <= j + 1'b1;
         end
      end
   end

   assign last = (i == LAST_IDX) && (j == LAST_IDX);

endmodule

// File: rtl/mul2x2_seq_scheduler.sv
// ---------------------------------------------------------------------------
// mul2x2_seq_scheduler
// Computes a WIDTH x WIDTH unsigned product by feeding every pair of 2-bit
// operand digits through one external combinational 2x2 multiplier core,
// one pair per cycle, and shift-accumulating the 4-bit partial products.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result handshake (slave side)
//   core_a     : digit of a presented to the core (0 outside RUN)
//   core_b     : digit of b presented to the core (0 outside RUN)
//   core_p     : product returned by the core
// Parameters:
//   WIDTH      : operand width, even and >= 2
//   SKIP_ZERO  : 1 = a zero operand returns 0 without using the core
// ---------------------------------------------------------------------------
module mul2x2_seq_scheduler
   import mulsched_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SKIP_ZERO = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   mul2x2_seq_scheduler_if.slave       bus,
   output logic [CORE_W-1:0]           core_a,
   output logic [CORE_W-1:0]           core_b,
   input  logic [2*CORE_W-1:0]         core_p
);

   localparam int K     = digits(WIDTH);
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam int PW    = 2 * WIDTH;

   state_t              state;
   logic [WIDTH-1:0]    a_r;
   logic [WIDTH-1:0]    b_r;
   logic [PW-1:0]       acc;
   logic [PW-1:0]       p_r;
   logic                out_valid_r;
   logic [PW-1:0]       term;
   logic [IDX_W-1:0]    dig_i;
   logic [IDX_W-1:0]    dig_j;
   logic                dig_last;
   logic                in_ready_c;
   logic                accept;
   logic                zero_skip;

   // The block can take a new pair when idle, or when the finished result
   // is being handed off this very cycle, so back-to-back jobs lose no cycle.
   assign in_ready_c = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign accept     = bus.in_valid && in_ready_c;
   assign zero_skip  = (SKIP_ZERO != 0) && ((bus.a == '0) || (bus.b == '0));

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_r;
   assign bus.p         = p_r;

   mul_digit_counter #(
      .K     (K),
      .IDX_W (IDX_W)
   ) u_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (state == RUN),
      .i      (dig_i),
      .j      (dig_j),
      .last   (dig_last)
   );

   // Present the current digit pair to the core only while running, and
   // weight its product by the combined digit position 2*(i+j).
   always_comb begin
      core_a = '0;
      core_b = '0;
      if (state == RUN) begin
         core_a = a_r[CORE_W*int'(dig_i) +: CORE_W];
         core_b = b_r[CORE_W*int'(dig_j) +: CORE_W];
      end
      term = PW'(core_p) << (CORE_W * (int'(dig_i) + int'(dig_j)));
   end

   // Controller and accumulator. An accept (only possible from IDLE or from
   // DONE during the output handshake) always restarts the job; otherwise
   // RUN accumulates one partial product per cycle and DONE holds the
   // result until the consumer takes it. p keeps its value back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_r         <= '0;
         b_r         <= '0;
         acc         <= '0;
         p_r         <= '0;
         out_valid_r <= 1'b0;
      end else if (accept) begin
         a_r <= bus.a;
         b_r <= bus.b;
         acc <= '0;
         if (zero_skip) begin
            state       <= DONE;
            p_r         <= '0;
            out_valid_r <= 1'b1;
         end else begin
            state       <= RUN;
            out_valid_r <= 1'b0;
         end
      end else begin
         case (state)
            RUN: begin
               acc <= acc + term;
               if (dig_last) begin
                  p_r         <= acc + term;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul2x2_seq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mul2x2_seq_scheduler
// Drives two schedulers (SKIP_ZERO=1 as index 0, SKIP_ZERO=0 as index 1),
// each attached to a 2x2 core model that can inject a 3x3=8 fault, and
// compares products and latencies against plain a*b arithmetic.
// ---------------------------------------------------------------------------
module tb_mul2x2_seq_scheduler;

   localparam int WIDTH = 8;
   localparam int KK    = (WIDTH / 2) * (WIDTH / 2);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fault;
   logic [1:0]  inValid;
   logic [7:0]  opA;
   logic [7:0]  opB;
   logic        outReady;

   logic [1:0]  coreA0, coreB0, coreA1, coreB1;
   logic [3:0]  coreP0, coreP1;

   logic [1:0]  inReadyObs;
   logic [1:0]  outValidObs;
   logic [15:0] pObs [2];
   logic [1:0]  coreAObs [2];
   logic [1:0]  coreBObs [2];

   int checks   = 0;
   int failures = 0;

   mul2x2_seq_scheduler_if #(.WIDTH(WIDTH)) bus0 ();
   mul2x2_seq_scheduler_if #(.WIDTH(WIDTH)) bus1 ();

   assign bus0.in_valid  = inValid[0];
   assign bus0.a         = opA;
   assign bus0.b         = opB;
   assign bus0.out_ready = outReady;
   assign bus1.in_valid  = inValid[1];
   assign bus1.a         = opA;
   assign bus1.b         = opB;
   assign bus1.out_ready = outReady;

   assign inReadyObs  = {bus1.in_ready, bus0.in_ready};
   assign outValidObs = {bus1.out_valid, bus0.out_valid};
   assign pObs[0]     = bus0.p;
   assign pObs[1]     = bus1.p;
   assign coreAObs[0] = coreA0;
   assign coreAObs[1] = coreA1;
   assign coreBObs[0] = coreB0;
   assign coreBObs[1] = coreB1;

   // Core models: ideal 2x2 product, or the faulty variant for 3x3.
   assign coreP0 = (fault && coreA0 == 2'b11 && coreB0 == 2'b11) ? 4'd8 :
                   ({2'b00, coreA0} * {2'b00, coreB0});
   assign coreP1 = (fault && coreA1 == 2'b11 && coreB1 == 2'b11) ? 4'd8 :
                   ({2'b00, coreA1} * {2'b00, coreB1});

   mul2x2_seq_scheduler #(.WIDTH(WIDTH), .SKIP_ZERO(1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus0),
      .core_a (coreA0),
      .core_b (coreB0),
      .core_p (coreP0)
   );

   mul2x2_seq_scheduler #(.WIDTH(WIDTH), .SKIP_ZERO(0)) dutNoSkip (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus1),
      .core_a (coreA1),
      .core_b (coreB1),
      .core_p (coreP1)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Edges from the accept edge until out_valid is seen, per the job rules.
   function automatic int expLatency(input int sel, input logic [7:0] ta, input logic [7:0] tb);
      if (sel == 0 && (ta == 0 || tb == 0)) return 0;
      return KK;
   endfunction

   // Offer one operand pair and return once it has been accepted; the
   // operand lines are then scrambled to show the job is insensitive to them.
   task automatic applyStimulus(input int sel, input logic [7:0] ta, input logic [7:0] tb);
      int waitCnt = 0;
      opA = ta;
      opB = tb;
      inValid[sel] = 1'b1;
      while (!inReadyObs[sel] && waitCnt < 50) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (waitCnt >= 50) checkOutput("acceptTimeout", 0, 1);
      @(posedge clk); #1;
      inValid[sel] = 1'b0;
      opA = 8'($urandom);
      opB = 8'($urandom);
   endtask

   task automatic waitResult(input int sel, output int lat);
      lat = 0;
      while (!outValidObs[sel] && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic takeResult();
      outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
   endtask

   initial begin
      int lat;
      logic [7:0] ra, rb;
      int hold;

      rst_n    = 1'b0;
      fault    = 1'b0;
      inValid  = 2'b00;
      opA      = 8'd0;
      opB      = 8'd0;
      outReady = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstOutValid", outValidObs[0], 0);
      checkOutput("rstP", pObs[0], 0);
      checkOutput("rstCoreA", coreAObs[0], 0);
      checkOutput("rstCoreB", coreBObs[0], 0);
      checkOutput("rstInReady", inReadyObs[0], 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full-scale operands.
      applyStimulus(0, 8'hFF, 8'hFF);
      checkOutput("ffCoreA", coreAObs[0], 3);
      checkOutput("ffCoreB", coreBObs[0], 3);
      checkOutput("ffInReadyBusy", inReadyObs[0], 0);
      waitResult(0, lat);
      checkOutput("ffLatency", lat, KK);
      checkOutput("ffP", pObs[0], 16'hFE01);
      takeResult();
      checkOutput("ffIdleValid", outValidObs[0], 0);

      // Zero operand with and without the bypass.
      applyStimulus(0, 8'd0, 8'hA5);
      checkOutput("zeroCoreA", coreAObs[0], 0);
      checkOutput("zeroCoreB", coreBObs[0], 0);
      waitResult(0, lat);
      checkOutput("zeroLatency", lat, 0);
      checkOutput("zeroP", pObs[0], 0);
      takeResult();
      applyStimulus(1, 8'd0, 8'hA5);
      waitResult(1, lat);
      checkOutput("noSkipLatency", lat, KK);
      checkOutput("noSkipP", pObs[1], 0);
      takeResult();

      // Consumer stalls for five cycles.
      applyStimulus(0, 8'd13, 8'd11);
      waitResult(0, lat);
      for (int c = 0; c < 5; c++) begin
         checkOutput("stallP", pObs[0], 143);
         checkOutput("stallValid", outValidObs[0], 1);
         checkOutput("stallInReady", inReadyObs[0], 0);
         @(posedge clk); #1;
      end
      takeResult();
      checkOutput("postStallValid", outValidObs[0], 0);
      checkOutput("postStallInReady", inReadyObs[0], 1);
      checkOutput("postStallP", pObs[0], 143);

      // New job accepted on the same edge as the output handshake.
      applyStimulus(0, 8'd13, 8'd11);
      waitResult(0, lat);
      outReady   = 1'b1;
      inValid[0] = 1'b1;
      opA        = 8'd3;
      opB        = 8'd3;
      @(posedge clk); #1;
      inValid[0] = 1'b0;
      outReady   = 1'b0;
      checkOutput("b2bValid", outValidObs[0], 0);
      checkOutput("b2bInReady", inReadyObs[0], 0);
      checkOutput("b2bCoreA", coreAObs[0], 3);
      waitResult(0, lat);
      checkOutput("b2bLatency", lat, KK);
      checkOutput("b2bP", pObs[0], 9);
      takeResult();

      // Reset in the middle of a job.
      applyStimulus(0, 8'd77, 8'd99);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abortValid", outValidObs[0], 0);
      checkOutput("abortP", pObs[0], 0);
      checkOutput("abortCoreA", coreAObs[0], 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(0, 8'd2, 8'd200);
      waitResult(0, lat);
      checkOutput("afterAbortLatency", lat, KK);
      checkOutput("afterAbortP", pObs[0], 400);
      takeResult();

      // Faulty core must show through.
      fault = 1'b1;
      applyStimulus(0, 8'h03, 8'h03);
      waitResult(0, lat);
      checkOutput("faultP", pObs[0], 8);
      takeResult();
      fault = 1'b0;

      // Random jobs against plain multiplication.
      for (int n = 0; n < 1000; n++) begin
         ra   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         rb   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         hold = $urandom_range(0, 2);
         applyStimulus(0, ra, rb);
         if (expLatency(0, ra, rb) != 0) begin
            checkOutput("rndCoreA", coreAObs[0], 32'(ra[1:0]));
            checkOutput("rndCoreB", coreBObs[0], 32'(rb[1:0]));
         end
         waitResult(0, lat);
         checkOutput("rndLatency", lat, expLatency(0, ra, rb));
         checkOutput("rndP", pObs[0], int'(ra) * int'(rb));
         for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            checkOutput("rndHoldP", pObs[0], int'(ra) * int'(rb));
         end
         takeResult();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
